// File: rtl/nary_gate_unit.sv
// N-input reducible gate (AND/OR/NAND/NOR/XOR/XNOR) with a valid/ready handshake and a result counter.
// Optional exhaustive input sweep is compiled in only when NARY_GATE_SWEEP_EN is defined.
module nary_gate_unit #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             answer,
  output logic             op_err,
  output logic [CNT_W-1:0] result_count,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101
  } op_e;

  logic             slot_free;
  logic             take;
  logic             delivery;
  logic             sweep_run;
  logic [WIDTH-1:0] gate_vec;
  logic             gate_result;
  logic             illegal_op;

  // Codes 110/111 fall through to the default and yield 0.
  function automatic logic gate_eval(input logic [WIDTH-1:0] v, input logic [2:0] o);
    logic r;
    r = 1'b0;
    case (o)
      OP_AND:  r = &v;
      OP_OR:   r = |v;
      OP_NAND: r = ~&v;
      OP_NOR:  r = ~|v;
      OP_XOR:  r = ^v;
      OP_XNOR: r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // The output register is free when empty or being drained this very cycle.
  assign slot_free   = !out_valid || out_ready;
  assign delivery    = out_valid && out_ready;
  assign in_ready    = !rst && !sweep_run && slot_free;
  assign take        = sweep_run ? slot_free : (in_valid && in_ready);
  assign illegal_op  = op[2] && op[1];
  assign gate_result = gate_eval(gate_vec, op);

`ifdef NARY_GATE_SWEEP_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sweep_state_e;

  sweep_state_e     state;
  logic [WIDTH-1:0] sweep_cnt;

  assign sweep_run = (state == S_RUN);
  assign gate_vec  = sweep_run ? sweep_cnt : in_vec;

  // The counter wraps to zero after the all-ones vector, so a finished sweep leaves it ready for the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sweep_cnt  <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sweep_start) begin
            state      <= S_RUN;
            sweep_busy <= 1'b1;
          end
        end
        S_RUN: begin
          if (take) begin
            sweep_cnt <= sweep_cnt + WIDTH'(1);
            if (&sweep_cnt) begin
              state      <= S_DONE;
              sweep_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          sweep_busy <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign sweep_run          = 1'b0;
  assign gate_vec           = in_vec;
  assign sweep_busy         = 1'b0;
  assign sweep_done         = 1'b0;
`endif

  // NOTE: every register here uses <= so all of them see pre-edge values of out_valid/out_ready;
  // blocking assignments would let the counter observe the already-updated out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      answer       <= 1'b0;
      op_err       <= 1'b0;
      result_count <= '0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        answer    <= gate_result;
        op_err    <= illegal_op;
      end else if (delivery) begin
        out_valid <= 1'b0;
      end
      if (delivery) begin
        result_count <= result_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nary_gate_unit.sv
// Randomized and directed bench for nary_gate_unit; two instances (CNT_W=8 and CNT_W=3) share all stimulus.
// The reference model works from ones-counts and transaction rules; sweep scenarios follow NARY_GATE_SWEEP_EN.
module tb_nary_gate_unit;
  localparam int W = 3;
`ifdef NARY_GATE_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sweep_start;
  logic [W-1:0] in_vec;
  logic [2:0]   op;
  logic         in_ready, out_valid, answer, op_err, sweep_busy, sweep_done;
  logic [7:0]   result_count;
  logic         in_ready_c, out_valid_c, answer_c, op_err_c, sweep_busy_c, sweep_done_c;
  logic [2:0]   result_count_c;

  nary_gate_unit #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .answer(answer), .op_err(op_err),
    .result_count(result_count), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done)
  );

  nary_gate_unit #(.WIDTH(W), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_vec(in_vec), .op(op),
    .out_valid(out_valid_c), .out_ready(out_ready), .answer(answer_c), .op_err(op_err_c),
    .result_count(result_count_c), .sweep_start(sweep_start), .sweep_busy(sweep_busy_c),
    .sweep_done(sweep_done_c)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: pending result, delivered count, sweep progress.
  bit m_valid, m_ans, m_err, m_run, m_done;
  int m_idx, m_cnt;
  bit got_q[$];
  int done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_gate(input int vec, input int o);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += (vec >> i) & 1;
    case (o)
      0: return ones == W;
      1: return ones != 0;
      2: return ones != W;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model across the posedge.
  task automatic step(input bit r, input bit iv, input int vec, input int o, input bit ordy, input bit ss);
    bit free, take, deliver, nxt_done;
    int v;
    @(negedge clk);
    rst = r; in_valid = iv; in_vec = vec[W-1:0]; op = o[2:0]; out_ready = ordy; sweep_start = ss;
    #1;
    check("out_valid", out_valid, m_valid);
    check("answer", answer, m_ans);
    check("op_err", op_err, m_err);
    check("result_count", result_count, m_cnt % 256);
    check("in_ready", in_ready, !r && !m_run && (!m_valid || ordy));
    check("sweep_busy", sweep_busy, m_run || m_done);
    check("sweep_done", sweep_done, m_done);
    check("c3_count", result_count_c, m_cnt % 8);
    check("c3_out_valid", out_valid_c, m_valid);
    check("c3_answer", answer_c, m_ans);
    check("c3_op_err", op_err_c, m_err);
    check("c3_in_ready", in_ready_c, !r && !m_run && (!m_valid || ordy));
    check("c3_sweep_busy", sweep_busy_c, m_run || m_done);
    check("c3_sweep_done", sweep_done_c, m_done);
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(answer);
    if (sweep_done === 1'b1) done_seen++;

    if (r) begin
      m_valid = 0; m_ans = 0; m_err = 0; m_cnt = 0; m_run = 0; m_done = 0; m_idx = 0;
    end else begin
      free    = !m_valid || ordy;
      deliver = m_valid && ordy;
      if (m_run) begin take = free; v = m_idx; end
      else begin take = iv && free; v = vec; end
      nxt_done = 0;
      if (m_run) begin
        if (take) begin
          if (m_idx == 2**W - 1) begin m_run = 0; nxt_done = 1; m_idx = 0; end
          else m_idx++;
        end
      end else if (!m_done && ss && SWEEP) begin
        m_run = 1;
      end
      m_done = nxt_done;
      if (take) begin
        m_valid = 1; m_ans = ref_gate(v, o); m_err = (o >= 6);
      end else if (deliver) begin
        m_valid = 0;
      end
      if (deliver) m_cnt++;
    end
    @(posedge clk);
  endtask

  initial begin
    int exp33[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int exp37[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int exp36[3] = '{7, 0, 1};
    int base;

    rst = 1; in_valid = 0; in_vec = '0; op = '0; out_ready = 0; sweep_start = 0;
    m_valid = 0; m_ans = 0; m_err = 0; m_cnt = 0; m_run = 0; m_done = 0; m_idx = 0;
    done_seen = 0;

    // Reset state
    step(1, 1, 7, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_answer", answer, 0);
    check("rst_op_err", op_err, 0);
    check("rst_count", result_count, 0);
    check("rst_busy", sweep_busy, 0);

    // AND over 000..111 streamed with out_ready held high
    got_q.delete();
    for (int v = 0; v < 8; v++) step(0, 1, v, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    #1;
    check("and_stream_count", result_count, 8);
    check("and_stream_n", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check("and_stream_ans", (i < got_q.size()) ? int'(got_q[i]) : -1, exp33[i]);

    // NOR of 000 held under backpressure, then released
    base = m_cnt;
    step(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, $urandom_range(7), 0, 0, 0);
      #1;
      check("bp_answer", answer, 1);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_count", result_count, base + 1);

    // Illegal op, then XOR of 101
    step(0, 1, $urandom_range(7), 6, 1, 0);
    #1;
    check("illegal_answer", answer, 0);
    check("illegal_err", op_err, 1);
    step(0, 1, 5, 4, 1, 0);
    #1;
    check("xor101_answer", answer, 0);
    check("xor101_err", op_err, 0);
    step(0, 0, 0, 0, 1, 0);

    // Narrow counter wraps: 7 -> 0 -> 1 across deliveries 7..9
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, k <= 9, $urandom_range(7), $urandom_range(5), 1, 0);
      #1;
      if (k >= 8) check("c3_wrap", result_count_c, exp36[k-8]);
    end

`ifdef NARY_GATE_SWEEP_EN
    // Full XOR sweep
    step(1, 0, 0, 0, 0, 0);
    got_q.delete();
    done_seen = 0;
    step(0, 0, 0, 4, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 4, 1, 0);
    #1;
    check("sweep_n", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check("sweep_ans", (i < got_q.size()) ? int'(got_q[i]) : -1, exp37[i]);
    check("sweep_done_once", done_seen, 1);
    check("sweep_idle_after", sweep_busy, 0);

    // Reset lands mid-sweep at vector 4
    step(1, 0, 0, 0, 0, 0);
    done_seen = 0;
    step(0, 0, 0, 4, 1, 1);
    for (int i = 0; i < 10 && m_idx != 4; i++) step(0, 0, 0, 4, 1, 0);
    check("sweep_at_vec4", m_idx, 4);
    step(1, 0, 0, 4, 1, 0);
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", sweep_busy, 0);
    check("mid_rst_count", result_count, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    check("mid_rst_no_done", done_seen, 0);
`else
    // Sweep logic absent: start pulse is ignored
    step(0, 0, 0, 4, 1, 1);
    step(0, 0, 0, 4, 1, 0);
    #1;
    check("nosweep_busy", sweep_busy, 0);
    check("nosweep_in_ready", in_ready, 1);
`endif

    // Random traffic
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 2, $urandom_range(1), $urandom_range(7), $urandom_range(7),
           $urandom_range(3) != 0, $urandom_range(9) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/nary_gate_unit.md
NARY_GATE_UNIT -- requirements
Module: nary_gate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 3, number of gate inputs (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the result counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream vector present.
REQ-006 SHALL have port in_ready  output  1  unit accepts a vector this cycle.
REQ-007 SHALL have port in_vec  input  WIDTH  gate input vector.
REQ-008 SHALL have port op  input  3  operation select, sampled with in_vec.
REQ-009 SHALL have port out_valid  output  1  answer holds a result.
REQ-010 SHALL have port out_ready  input  1  downstream takes the result.
REQ-011 SHALL have port answer  output  1  registered gate result.
REQ-012 SHALL have port op_err  output  1  registered flag: result came from an illegal op.
REQ-013 SHALL have port result_count  output  CNT_W  number of results delivered.
REQ-014 SHALL have port sweep_start  input  1  one-cycle pulse that starts the exhaustive sweep.
REQ-015 SHALL have port sweep_busy  output  1  sweep in progress.
REQ-016 SHALL have port sweep_done  output  1  one-cycle pulse at sweep end.

Function
REQ-017 SHALL decode op as 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, reduced over all WIDTH bits.
REQ-018 SHALL, for op 110/111, register answer=0 and op_err=1; legal ops register op_err=0.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (outside sweep); accept means in_valid && in_ready.
REQ-020 SHALL register answer/op_err and set out_valid on the edge after accept (latency 1 cycle).
REQ-021 SHALL hold answer, op_err, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL support back-to-back accepts: simultaneous delivery and accept replaces the result with out_valid staying 1.
REQ-023 SHALL clear out_valid after delivery (out_valid && out_ready) when there is no accept in the same cycle.
REQ-024 SHALL increment result_count on every delivery, wrapping from 2^CNT_W-1 to 0.
REQ-025 SHALL implement sweep FSM IDLE -> RUN on sweep_start in IDLE; RUN -> DONE after vector 2^WIDTH-1 is accepted; DONE -> IDLE unconditionally.
REQ-026 SHALL, in RUN, drive the gate from an internal counter 0..2^WIDTH-1 in place of in_vec, advancing one per internal accept, with op still taken from the op port.
REQ-027 SHALL, in RUN, hold in_ready=0 and ignore in_valid; the internal accept obeys the same out_ready backpressure.
REQ-028 SHALL assert sweep_busy in RUN and DONE, sweep_done for exactly the DONE cycle, and ignore sweep_start outside IDLE.

Reset
REQ-029 SHALL, while rst=1 at an edge, set out_valid=0, answer=0, op_err=0, result_count=0, sweep FSM=IDLE, sweep counter=0, sweep_done=0.
REQ-030 SHALL drive in_ready=0 while rst=1 and discard an in-flight result or an active sweep with no sweep_done pulse.

Configuration
REQ-031 SHALL compile the sweep FSM only when macro NARY_GATE_SWEEP_EN is defined.
REQ-032 SHALL, without NARY_GATE_SWEEP_EN, keep all ports, ignore sweep_start, tie sweep_busy=0 and sweep_done=0, and always source vectors from in_vec.

Verification
REQ-033 SHALL cover: WIDTH=3, op=000, vectors 000..111 streamed with out_ready=1 -> answer 0 seven times then 1; result_count=8.
REQ-034 SHALL cover: op=011, in_vec=000 accepted, out_ready=0 for 5 cycles -> answer=1 and out_valid held; in_ready=0; one delivery on release.
REQ-035 SHALL cover: op=110, any vector -> answer=0, op_err=1; next op=100 with in_vec=101 -> answer=0, op_err=0.
REQ-036 SHALL cover: CNT_W=3, 9 deliveries -> result_count 7 then 0 then 1.
REQ-037 SHALL cover: NARY_GATE_SWEEP_EN defined, WIDTH=3, op=100, sweep_start pulse, out_ready=1 -> 8 results 0,1,1,0,1,0,0,1; sweep_done exactly once, then IDLE.
REQ-038 SHALL cover: rst asserted mid-sweep at vector 4 -> next cycle out_valid=0, sweep_busy=0, result_count=0, no sweep_done.
